// File: rtl/piece_move_ctrl.sv
// Active-piece owner for the 12x12 board: spawn, checker-driven rotation, left/right/down shifts.
// Optional build macro WALL_KICK_EN enables right/left wall-kick retries on a rejected rotation.
module piece_move_ctrl #(
    parameter int unsigned ROT_LATENCY = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         spawn,
    input  logic [143:0] spawnSqs,
    input  logic [9:0]   spawnCenter,
    input  logic         rotReq,
    input  logic         leftReq,
    input  logic         rightReq,
    input  logic         downReq,
    input  logic [143:0] backGround,
    output logic [143:0] rotSqs,
    output logic [9:0]   rotCenter,
    output logic [10:0]  rotOffsetX,
    output logic [10:0]  rotOffsetY,
    input  logic [143:0] rotNewSqs,
    input  logic         rotCanRotate,
    output logic [143:0] pieceSqs,
    output logic [9:0]   centerPoint,
    output logic         busy,
    output logic         done,
    output logic         accepted,
    output logic         landed
);

    localparam int unsigned N_SQ  = 144;
    localparam int unsigned COLS  = 12;
    localparam int unsigned CW    = 10;
    localparam int unsigned OW    = 11;
    localparam int unsigned CNT_W = (ROT_LATENCY > 1) ? $clog2(ROT_LATENCY) : 1;

    function automatic logic [N_SQ-1:0] col_mask(input int unsigned col);
        logic [N_SQ-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < N_SQ; i++) begin
            if ((i % COLS) == col) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [N_SQ-1:0] COL_FIRST_MASK = col_mask(0);
    localparam logic [N_SQ-1:0] COL_LAST_MASK  = col_mask(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ROT_WAIT, S_ROT_CHECK, S_SHIFT, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_DOWN, OP_LEFT, OP_RIGHT, OP_KICK
    } op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_SQ-1:0]   piece_q, piece_d;
    logic [CW-1:0]     center_q, center_d;
    logic [N_SQ-1:0]   rot_sqs_q, rot_sqs_d;
    logic [CW-1:0]     rot_center_q, rot_center_d;
    logic [OW-1:0]     off_x_q, off_x_d;
    logic [OW-1:0]     off_y_q, off_y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accepted_q, accepted_d;
    logic              landed_q, landed_d;
    logic              rot_load;
`ifdef WALL_KICK_EN
    logic [1:0]        kick_q, kick_d;
`endif

    logic [N_SQ-1:0]   cand_down, cand_left, cand_right;
    logic              blk_down, blk_left, blk_right;
    logic [CW-1:0]     rx, ry;

    // Candidate shifted pieces and their wall/background collisions.
    always_comb begin
        cand_down  = piece_q << COLS;
        cand_left  = piece_q >> 1;
        cand_right = piece_q << 1;
        blk_down   = (|piece_q[N_SQ-1 -: COLS]) || (|(cand_down & backGround));
        blk_left   = (|(piece_q & COL_FIRST_MASK)) || (|(cand_left & backGround));
        blk_right  = (|(piece_q & COL_LAST_MASK)) || (|(cand_right & backGround));
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        piece_d      = piece_q;
        center_d     = center_q;
        rot_sqs_d    = rot_sqs_q;
        rot_center_d = rot_center_q;
        rot_load     = 1'b0;
        accepted_d   = 1'b0;
        landed_d     = 1'b0;
`ifdef WALL_KICK_EN
        kick_d       = kick_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (spawn) begin
                    piece_d    = spawnSqs;
                    center_d   = spawnCenter;
                    accepted_d = 1'b1;
                    state_d    = S_DONE;
                end else if (rotReq) begin
                    rot_sqs_d    = piece_q;
                    rot_center_d = center_q;
                    rot_load     = 1'b1;
                    cnt_d        = '0;
`ifdef WALL_KICK_EN
                    kick_d       = 2'd0;
`endif
                    state_d      = S_ROT_WAIT;
                end else if (downReq) begin
                    op_d    = OP_DOWN;
                    state_d = S_SHIFT;
                end else if (leftReq) begin
                    op_d    = OP_LEFT;
                    state_d = S_SHIFT;
                end else if (rightReq) begin
                    op_d    = OP_RIGHT;
                    state_d = S_SHIFT;
                end
            end
            S_ROT_WAIT: begin
                if (cnt_q == CNT_W'(ROT_LATENCY - 1)) state_d = S_ROT_CHECK;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            S_ROT_CHECK: begin
                // rot_center_q equals the committed centre unless a kick moved it.
                if (rotCanRotate) begin
                    piece_d    = rotNewSqs;
                    center_d   = rot_center_q;
                    accepted_d = 1'b1;
                    state_d    = S_DONE;
                end
`ifdef WALL_KICK_EN
                else if (kick_q != 2'd2) begin
                    op_d    = OP_KICK;
                    state_d = S_SHIFT;
                end
`endif
                else begin
                    state_d = S_DONE;
                end
            end
            S_SHIFT: begin
                state_d = S_DONE;
                case (op_q)
                    OP_DOWN: begin
                        if (blk_down) begin
                            landed_d = 1'b1;
                        end else begin
                            piece_d    = cand_down;
                            center_d   = center_q + CW'(COLS);
                            accepted_d = 1'b1;
                        end
                    end
                    OP_LEFT: begin
                        if (!blk_left) begin
                            piece_d    = cand_left;
                            center_d   = center_q - CW'(1);
                            accepted_d = 1'b1;
                        end
                    end
                    OP_RIGHT: begin
                        if (!blk_right) begin
                            piece_d    = cand_right;
                            center_d   = center_q + CW'(1);
                            accepted_d = 1'b1;
                        end
                    end
`ifdef WALL_KICK_EN
                    OP_KICK: begin
                        // Kicks always start from the committed piece, never from a prior kick.
                        cnt_d = '0;
                        if ((kick_q == 2'd0) && !blk_right) begin
                            rot_sqs_d    = cand_right;
                            rot_center_d = center_q + CW'(1);
                            rot_load     = 1'b1;
                            kick_d       = 2'd1;
                            state_d      = S_ROT_WAIT;
                        end else if (!blk_left) begin
                            rot_sqs_d    = cand_left;
                            rot_center_d = center_q - CW'(1);
                            rot_load     = 1'b1;
                            kick_d       = 2'd2;
                            state_d      = S_ROT_WAIT;
                        end
                    end
`endif
                    default: state_d = S_DONE;
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Checker offsets follow the centre being presented; updated only when it is reloaded.
    always_comb begin
        rx      = rot_center_d / CW'(COLS);
        ry      = rot_center_d % CW'(COLS);
        off_x_d = off_x_q;
        off_y_d = off_y_q;
        if (rot_load) begin
            off_x_d = OW'(ry) - OW'(rx);
            off_y_d = OW'(COLS - 1) - OW'(rx) - OW'(ry);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            op_q         <= OP_DOWN;
            cnt_q        <= '0;
            piece_q      <= '0;
            center_q     <= '0;
            rot_sqs_q    <= '0;
            rot_center_q <= '0;
            off_x_q      <= '0;
            off_y_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            accepted_q   <= 1'b0;
            landed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            piece_q      <= piece_d;
            center_q     <= center_d;
            rot_sqs_q    <= rot_sqs_d;
            rot_center_q <= rot_center_d;
            off_x_q      <= off_x_d;
            off_y_q      <= off_y_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            accepted_q   <= accepted_d;
            landed_q     <= landed_d;
        end
    end

`ifdef WALL_KICK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) kick_q <= 2'd0;
        else         kick_q <= kick_d;
    end
`endif

    assign rotSqs      = rot_sqs_q;
    assign rotCenter   = rot_center_q;
    assign rotOffsetX  = off_x_q;
    assign rotOffsetY  = off_y_q;
    assign pieceSqs    = piece_q;
    assign centerPoint = center_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign accepted    = accepted_q;
    assign landed      = landed_q;

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Directed bench for piece_move_ctrl with a small latency-accurate rotation checker model.
module tb_piece_move_ctrl;

    localparam int unsigned L = 2;

    logic         clk = 1'b0;
    logic         resetn;
    logic         spawn, rotReq, leftReq, rightReq, downReq;
    logic [143:0] spawnSqs, backGround;
    logic [9:0]   spawnCenter;
    logic [143:0] rotSqs, rotNewSqs, pieceSqs;
    logic [9:0]   rotCenter, centerPoint;
    logic [10:0]  rotOffsetX, rotOffsetY;
    logic         rotCanRotate, busy, done, accepted, landed;

    piece_move_ctrl #(.ROT_LATENCY(L)) dut (
        .clk(clk), .resetn(resetn), .spawn(spawn), .spawnSqs(spawnSqs),
        .spawnCenter(spawnCenter), .rotReq(rotReq), .leftReq(leftReq),
        .rightReq(rightReq), .downReq(downReq), .backGround(backGround),
        .rotSqs(rotSqs), .rotCenter(rotCenter), .rotOffsetX(rotOffsetX),
        .rotOffsetY(rotOffsetY), .rotNewSqs(rotNewSqs), .rotCanRotate(rotCanRotate),
        .pieceSqs(pieceSqs), .centerPoint(centerPoint), .busy(busy), .done(done),
        .accepted(accepted), .landed(landed)
    );

    always #5 clk = ~clk;

    // Checker model: answers only once rotSqs/rotCenter have been stable for two cycles,
    // and accepts only the centre held in tb_ok.
    logic [143:0] p1_s = '0, p2_s = '0, tb_new = '0;
    logic [9:0]   p1_c = '0, p2_c = '0, tb_ok = '1;
    logic         match;
    always @(posedge clk) begin
        p1_s <= rotSqs; p1_c <= rotCenter;
        p2_s <= p1_s;   p2_c <= p1_c;
    end
    assign match        = (p2_s == rotSqs) && (p2_c == rotCenter);
    assign rotNewSqs    = match ? tb_new : '0;
    assign rotCanRotate = match && (rotCenter == tb_ok);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] bm(input int a, input int b = -1, input int c = -1,
                                        input int d = -1);
        logic [143:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        if (d >= 0) m[d] = 1'b1;
        return m;
    endfunction

    // One idle edge, then present the request across the sampling edge.
    task automatic issue(input logic sp, input logic rt, input logic dn, input logic lf,
                         input logic rg);
        @(posedge clk); #1;
        spawn = sp; rotReq = rt; downReq = dn; leftReq = lf; rightReq = rg;
        @(posedge clk); #1;
        spawn = 1'b0; rotReq = 1'b0; downReq = 1'b0; leftReq = 1'b0; rightReq = 1'b0;
    endtask

    // Edges from the sampling edge until done is seen; bounded.
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_spawn(input logic [143:0] sqs, input logic [9:0] c);
        int lat;
        spawnSqs = sqs; spawnCenter = c;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done(1, lat);
        check("spawn_lat", lat, 1);
        check("spawn_piece", pieceSqs, sqs);
    endtask

    task automatic expect_done(input string tag, input int lat, input int lat_exp,
                               input logic acc, input logic lnd,
                               input logic [143:0] sqs, input logic [9:0] c);
        check({tag, "_lat"}, lat, lat_exp);
        check({tag, "_acc"}, accepted, acc);
        check({tag, "_land"}, landed, lnd);
        check({tag, "_piece"}, pieceSqs, sqs);
        check({tag, "_centre"}, centerPoint, c);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_piece"}, pieceSqs, '0);
        check({tag, "_centre"}, centerPoint, '0);
        check({tag, "_rotsqs"}, rotSqs, '0);
        check({tag, "_rotc"}, rotCenter, '0);
        check({tag, "_offx"}, rotOffsetX, '0);
        check({tag, "_offy"}, rotOffsetY, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_acc"}, accepted, 1'b0);
        check({tag, "_land"}, landed, 1'b0);
    endtask

    initial begin
        int lat;
        int extra;
        logic [143:0] p_b, new1, new2;
        p_b  = bm(16, 17, 18, 29);
        new1 = bm(5, 17, 28, 29);
        new2 = bm(5, 16, 17, 18);

        resetn = 1'b0; spawn = 1'b0; rotReq = 1'b0; leftReq = 1'b0; rightReq = 1'b0;
        downReq = 1'b0; spawnSqs = '0; spawnCenter = '0; backGround = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) resetn = 1'b1;

        // Spawn then move down on an empty board.
        do_spawn(bm(4, 5, 6, 17), 10'd5);
        check("spawn_centre", centerPoint, 10'd5);
        check("spawn_acc", accepted, 1'b1);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done(1, lat);
        expect_done("down_ok", lat, 2, 1'b1, 1'b0, p_b, 10'd17);

        // Rotation accepted; checker sees the committed piece and centre 17.
        tb_ok = 10'd17; tb_new = new1;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rot_busy", busy, 1'b1);
        check("rot_sqs", rotSqs, p_b);
        check("rot_centre", rotCenter, 10'd17);
        check("rot_offx", rotOffsetX, 11'd4);
        check("rot_offy", rotOffsetY, 11'd5);
        wait_done(1, lat);
        expect_done("rot_ok", lat, L + 2, 1'b1, 1'b0, new1, 10'd17);

        // Rotation rejected: piece unchanged.
        tb_ok = 10'h3FF; tb_new = new2;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(1, lat);
`ifdef WALL_KICK_EN
        expect_done("rot_rej", lat, 3 * L + 6, 1'b0, 1'b0, new1, 10'd17);
`else
        expect_done("rot_rej", lat, L + 2, 1'b0, 1'b0, new1, 10'd17);
`endif

        // rotReq beats leftReq; leftReq while busy is dropped.
        tb_ok = 10'd17; tb_new = new2;
        issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        leftReq = 1'b1;
        @(posedge clk); #1;
        leftReq = 1'b0;
        wait_done(2, lat);
        expect_done("rot_prio", lat, L + 2, 1'b1, 1'b0, new2, 10'd17);
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        check("dropped_left_done", extra, 0);
        check("dropped_left_centre", centerPoint, 10'd17);

        // Down blocked by bottom row.
        do_spawn(bm(132), 10'd132);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done(1, lat);
        expect_done("down_floor", lat, 2, 1'b0, 1'b1, bm(132), 10'd132);

        // Down blocked by background.
        do_spawn(bm(5), 10'd5);
        backGround = bm(17);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done(1, lat);
        expect_done("down_bg", lat, 2, 1'b0, 1'b1, bm(5), 10'd5);
        backGround = '0;

        // Left wall, right background, then free right and left moves.
        do_spawn(bm(12), 10'd12);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_done(1, lat);
        expect_done("left_wall", lat, 2, 1'b0, 1'b0, bm(12), 10'd12);
        backGround = bm(13);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(1, lat);
        expect_done("right_bg", lat, 2, 1'b0, 1'b0, bm(12), 10'd12);
        backGround = '0;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(1, lat);
        expect_done("right_ok", lat, 2, 1'b1, 1'b0, bm(13), 10'd13);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_done(1, lat);
        expect_done("left_ok", lat, 2, 1'b1, 1'b0, bm(12), 10'd12);

        // Right wall.
        do_spawn(bm(23), 10'd23);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(1, lat);
        expect_done("right_wall", lat, 2, 1'b0, 1'b0, bm(23), 10'd23);

        // Reset in ROT_WAIT aborts everything; next rotation runs normally.
        do_spawn(p_b, 10'd17);
        tb_ok = 10'd17; tb_new = new1;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_busy", busy, 1'b1);
        resetn = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk) resetn = 1'b1;
        do_spawn(p_b, 10'd17);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(1, lat);
        expect_done("rot_after_abort", lat, L + 2, 1'b1, 1'b0, new1, 10'd17);

`ifdef WALL_KICK_EN
        // Reject at centre 17, accept on kick 1 at centre 18.
        tb_ok = 10'd18; tb_new = new2;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(1, lat);
        expect_done("kick1", lat, 2 * L + 4, 1'b1, 1'b0, new2, 10'd18);
`endif

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
